// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard: the tracking-entry
// layout, the forward-select encoding and the producer latency classes.
package fwd_pkg;

    // Entries store the destination at a fixed width so the type is independent of AW (AW <= RD_W)
    localparam int RD_W = 8;

    localparam int FWD_RF = 0;

    localparam logic [2:0] LAT_ALU  = 3'd1;
    localparam logic [2:0] LAT_LOAD = 3'd2;
    localparam logic [2:0] LAT_MUL  = 3'd3;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic [2:0]      lat;
    } entry_t;

    // Latency 0 means single-cycle; anything above the pipeline's maximum is clamped to it
    function automatic logic [2:0] normLat(input logic [2:0] lat, input int maxLat);
        if (lat == 3'd0) begin
            return LAT_ALU;
        end
        if (int'(lat) > maxLat) begin
            return 3'(maxLat);
        end
        return lat;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue-side bus between the ID stage (master) and the forwarding scoreboard (slave).
interface fwd_scoreboard_if #(
    parameter int AW = 5,
    parameter int SW = 3
);

    logic          iss_valid;
    logic [AW-1:0] iss_rs;
    logic [AW-1:0] iss_rt;
    logic          iss_wen;
    logic [AW-1:0] iss_rd;
    logic [2:0]    iss_lat;
    logic          iss_br;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
    logic [31:0]   stall_cnt;

    modport master (
        output iss_valid, iss_rs, iss_rt, iss_wen, iss_rd, iss_lat, iss_br, flush,
        input  stall, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  iss_valid, iss_rs, iss_rt, iss_wen, iss_rd, iss_lat, iss_br, flush,
        output stall, fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/fwd_scoreboard_match.sv
// Per-operand lookup: finds the youngest in-flight producer of a source register
// and decides whether its result can be bypassed yet.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int AW       = 5,
    parameter int D        = 4,
    parameter int SW       = 3,
    parameter int BR_EXTRA = 1
) (
    input  entry_t [D:1]  i_chain,
    input  logic [AW-1:0] i_src,
    input  logic          i_br,
    output logic [SW-1:0] o_sel,
    output logic          o_notReady
);

    logic w_hit;
    int   w_age;
    int   w_need;

    // Walk oldest to youngest so the youngest hit overwrites any older, shadowed one
    always_comb begin
        w_hit  = 1'b0;
        w_age  = 0;
        w_need = 0;
        for (int k = D; k >= 1; k--) begin
            if (i_src != '0 && i_chain[k].valid && i_chain[k].rd == RD_W'(i_src)) begin
                w_hit  = 1'b1;
                w_age  = k;
                w_need = int'(i_chain[k].lat) + (i_br ? BR_EXTRA : 0);
            end
        end

        o_sel      = SW'(FWD_RF);
        o_notReady = 1'b0;
        if (w_hit) begin
            if (w_age >= w_need) begin
                o_sel = SW'(w_age);
            end else begin
                o_notReady = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writes by age and drives bypass
// selects and the load-use/branch stall. Define FWD_SCOREBOARD_STALL_CNT_EN for stall_cnt.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int AW       = 5,
    parameter int MAX_LAT  = 3,
    parameter int BR_EXTRA = 1
) (
    input logic             clk,
    input logic             rst_n,
    fwd_scoreboard_if.slave bus
);

    localparam int D  = MAX_LAT + BR_EXTRA;
    localparam int SW = $clog2(D + 1);

    entry_t [D:1]  r_chain;
    entry_t        w_entryIn;
    logic [SW-1:0] w_selA;
    logic [SW-1:0] w_selB;
    logic          w_nrA;
    logic          w_nrB;
    logic          w_stall;

    fwd_match #(.AW(AW), .D(D), .SW(SW), .BR_EXTRA(BR_EXTRA)) u_matchRs (
        .i_chain    (r_chain),
        .i_src      (bus.iss_rs),
        .i_br       (bus.iss_br),
        .o_sel      (w_selA),
        .o_notReady (w_nrA)
    );

    fwd_match #(.AW(AW), .D(D), .SW(SW), .BR_EXTRA(BR_EXTRA)) u_matchRt (
        .i_chain    (r_chain),
        .i_src      (bus.iss_rt),
        .i_br       (bus.iss_br),
        .o_sel      (w_selB),
        .o_notReady (w_nrB)
    );

    // A flush kills the ID instruction, so it can never also be the one stalling
    always_comb begin
        w_stall = rst_n & bus.iss_valid & ~bus.flush & (w_nrA | w_nrB);
    end

    assign bus.stall = w_stall;
    assign bus.fwd_a = (rst_n && bus.iss_valid) ? w_selA : SW'(FWD_RF);
    assign bus.fwd_b = (rst_n && bus.iss_valid) ? w_selB : SW'(FWD_RF);

    // Writes to r0 are never tracked since r0 is hardwired
    always_comb begin
        w_entryIn = '0;
        if (bus.iss_valid && bus.iss_wen && !w_stall && !bus.flush && bus.iss_rd != '0) begin
            w_entryIn.valid = 1'b1;
            w_entryIn.rd    = RD_W'(bus.iss_rd);
            w_entryIn.lat   = normLat(bus.iss_lat, MAX_LAT);
        end
    end

    // Shift every cycle, stall or not; the producer one stage ahead of ID dies on flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain[1] <= w_entryIn;
            for (int k = 2; k <= D; k++) begin
                r_chain[k] <= (k == 2 && bus.flush) ? entry_t'('0) : r_chain[k-1];
            end
        end
    end

`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (w_stall && r_stallCnt != 32'hFFFF_FFFF) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stallCnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard: directed hazard scenarios plus random issue traffic,
// all checked against an issue-history reference model.
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    localparam int AW       = 5;
    localparam int MAX_LAT  = 3;
    localparam int BR_EXTRA = 1;
    localparam int D        = MAX_LAT + BR_EXTRA;
    localparam int SW       = $clog2(D + 1);
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.AW(AW), .SW(SW)) bus ();

    fwd_scoreboard #(.AW(AW), .MAX_LAT(MAX_LAT), .BR_EXTRA(BR_EXTRA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: a log of accepted register writes, each stamped with its issue cycle
    typedef struct {
        int cyc;
        int rd;
        int lat;
    } rec_t;

    rec_t        issued[$];
    int          cycleNo;
    logic [31:0] cntModel;
    int          compareCount;
    int          failCount;
    logic [31:0] lastStall;
    logic [31:0] lastFwdA;
    logic [31:0] lastFwdB;
    logic [31:0] lastCnt;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycleNo);
        end
    endtask

    // Youngest write to src still within the tracking window decides everything
    function automatic void lookup(input int src, input bit br, output int sel, output bit nr);
        int bestCyc;
        int bestLat;
        sel     = 0;
        nr      = 1'b0;
        bestCyc = -1;
        bestLat = 0;
        if (src == 0) return;
        foreach (issued[i]) begin
            int age;
            age = cycleNo - issued[i].cyc;
            if (age >= 1 && age <= D && issued[i].rd == src && issued[i].cyc > bestCyc) begin
                bestCyc = issued[i].cyc;
                bestLat = issued[i].lat;
            end
        end
        if (bestCyc >= 0) begin
            if (cycleNo - bestCyc >= bestLat + (br ? BR_EXTRA : 0)) sel = cycleNo - bestCyc;
            else nr = 1'b1;
        end
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input int rs, input int rt,
                                 input bit wen, input int rd, input int lat,
                                 input bit br, input bit fl);
        int selA;
        int selB;
        bit nrA;
        bit nrB;
        bit expStall;
        int effLat;
        rst_n         = r;
        bus.iss_valid = v;
        bus.iss_rs    = AW'(rs);
        bus.iss_rt    = AW'(rt);
        bus.iss_wen   = wen;
        bus.iss_rd    = AW'(rd);
        bus.iss_lat   = 3'(lat);
        bus.iss_br    = br;
        bus.flush     = fl;
        #4;
        lookup(rs, br, selA, nrA);
        lookup(rt, br, selB, nrB);
        expStall  = r && v && !fl && (nrA || nrB);
        lastStall = 32'(bus.stall);
        lastFwdA  = 32'(bus.fwd_a);
        lastFwdB  = 32'(bus.fwd_b);
        lastCnt   = bus.stall_cnt;
        checkOutput("stall", lastStall, 32'(expStall));
        checkOutput("fwd_a", lastFwdA, (r && v) ? selA : 0);
        checkOutput("fwd_b", lastFwdB, (r && v) ? selB : 0);
        checkOutput("stall_cnt", lastCnt, cntModel);

        if (!r) begin
            issued.delete();
            cntModel = '0;
        end else begin
            if (fl) begin
                for (int i = issued.size() - 1; i >= 0; i--) begin
                    if (issued[i].cyc == cycleNo - 1) issued.delete(i);
                end
            end
            effLat = (lat == 0) ? 1 : ((lat > MAX_LAT) ? MAX_LAT : lat);
            if (v && wen && !expStall && !fl && rd != 0) issued.push_back('{cycleNo, rd, effLat});
            if (CntEn && expStall && cntModel != 32'hFFFF_FFFF) cntModel = cntModel + 1;
        end
        cycleNo++;
        while (issued.size() > 0 && cycleNo - issued[0].cyc > D) void'(issued.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        compareCount  = 0;
        failCount     = 0;
        cycleNo       = 0;
        cntModel      = '0;
        rst_n         = 1'b0;
        bus.iss_valid = 1'b0;
        bus.iss_rs    = '0;
        bus.iss_rt    = '0;
        bus.iss_wen   = 1'b0;
        bus.iss_rd    = '0;
        bus.iss_lat   = '0;
        bus.iss_br    = 1'b0;
        bus.flush     = 1'b0;
        @(posedge clk);
        #1;

        // Reset: outputs quiet even with an issuing instruction present
        applyStimulus(0, 1, 3, 4, 1, 3, 1, 1, 0);
        applyStimulus(0, 1, 3, 4, 1, 3, 1, 1, 0);
        checkOutput("rstStall", lastStall, 0);

        // ALU result bypassed from age 1
        applyStimulus(1, 1, 1, 2, 1, 3, LAT_ALU, 0, 0);
        applyStimulus(1, 1, 3, 0, 0, 0, 1, 0, 0);
        checkOutput("aluFwdA", lastFwdA, 1);
        checkOutput("aluStall", lastStall, 0);
        idleCycles(D);

        // Load-use: one bubble, then bypass from age 2
        applyStimulus(1, 1, 0, 0, 1, 4, LAT_LOAD, 0, 0);
        applyStimulus(1, 1, 0, 4, 0, 0, 1, 0, 0);
        checkOutput("loadStall", lastStall, 1);
        applyStimulus(1, 1, 0, 4, 0, 0, 1, 0, 0);
        checkOutput("loadFwdB", lastFwdB, 2);
        checkOutput("loadNoStall", lastStall, 0);
        idleCycles(D);

        // Branch on a load result needs one extra cycle
        applyStimulus(1, 1, 0, 0, 1, 5, LAT_LOAD, 0, 0);
        applyStimulus(1, 1, 5, 0, 0, 0, 1, 1, 0);
        checkOutput("brStall1", lastStall, 1);
        applyStimulus(1, 1, 5, 0, 0, 0, 1, 1, 0);
        checkOutput("brStall2", lastStall, 1);
        applyStimulus(1, 1, 5, 0, 0, 0, 1, 1, 0);
        checkOutput("brFwdA", lastFwdA, 3);
        checkOutput("brNoStall", lastStall, 0);
        idleCycles(D);

        // Youngest of two writers wins, on both operands
        applyStimulus(1, 1, 0, 0, 1, 6, LAT_LOAD, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 6, LAT_ALU, 0, 0);
        applyStimulus(1, 1, 6, 6, 0, 0, 1, 0, 0);
        checkOutput("youngFwdA", lastFwdA, 1);
        checkOutput("youngFwdB", lastFwdB, 1);
        idleCycles(D);

        // r0 is never forwarded
        applyStimulus(1, 1, 0, 0, 1, 0, LAT_MUL, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("r0FwdA", lastFwdA, 0);
        checkOutput("r0Stall", lastStall, 0);
        idleCycles(D);

        // Flush kills the multiply one stage ahead and suppresses stall
        applyStimulus(1, 1, 0, 0, 1, 7, LAT_MUL, 0, 0);
        applyStimulus(1, 1, 7, 0, 0, 0, 1, 0, 1);
        checkOutput("flushStall", lastStall, 0);
        applyStimulus(1, 1, 7, 7, 0, 0, 1, 0, 0);
        checkOutput("flushFwdA", lastFwdA, 0);
        checkOutput("flushNoStall", lastStall, 0);
        idleCycles(D);

        // Reset during a stall clears it and empties the scoreboard
        applyStimulus(1, 1, 0, 0, 1, 4, LAT_LOAD, 0, 0);
        applyStimulus(1, 1, 4, 0, 0, 0, 1, 0, 0);
        checkOutput("midStall", lastStall, 1);
        applyStimulus(0, 1, 4, 0, 0, 0, 1, 0, 0);
        checkOutput("rstMidStall", lastStall, 0);
        applyStimulus(1, 1, 4, 0, 0, 0, 1, 0, 0);
        checkOutput("postRstStall", lastStall, 0);
        checkOutput("postRstFwdA", lastFwdA, 0);

        // Five stall cycles: 3 from mul->branch, 1 each from two load-uses
        applyStimulus(1, 1, 0, 0, 1, 5, LAT_MUL, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 5, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 5, 0, 0, 0, 1, 1, 0);
        checkOutput("mulBrFwdA", lastFwdA, 4);
        for (int j = 0; j < 2; j++) begin
            applyStimulus(1, 1, 0, 0, 1, 4, LAT_LOAD, 0, 0);
            applyStimulus(1, 1, 4, 0, 0, 0, 1, 0, 0);
            applyStimulus(1, 1, 4, 0, 0, 0, 1, 0, 0);
        end
        idleCycles(1);
        checkOutput("stallCnt5", lastCnt, CntEn ? 32'd5 : 32'd0);

`ifdef FWD_SCOREBOARD_STALL_CNT_EN
        force dut.r_stallCnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_stallCnt;
        cntModel = 32'hFFFF_FFFD;
        applyStimulus(1, 1, 0, 0, 1, 5, LAT_MUL, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 5, 0, 0, 0, 1, 1, 0);
        idleCycles(1);
        checkOutput("stallCntSat", lastCnt, 32'hFFFF_FFFF);
`endif

        // Random issue traffic with occasional flush and reset
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 9) < 8,
                          int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
